// File: rtl/io_sw_debounce_if.sv
// Switch-port bundle between the raw switch pins and the debounced switch word.
// Latency: none (plain wiring); the debouncer registers every output.
// Backpressure: none; levels and pulses are free-running, i_ack is a level.
//
// Signals:
//   i_sw_raw     raw asynchronous switch levels (into the debouncer)
//   i_ack        clears the sticky changed flag (into the debouncer)
//   o_io_sw      debounced switch word
//   o_sw_rise    per-bit one-cycle pulse on an accepted 0->1
//   o_sw_fall    per-bit one-cycle pulse on an accepted 1->0
//   o_sw_changed sticky "some switch changed since last ack"
//   o_tick       one-cycle sample-strobe pulse
interface io_sw_debounce_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_sw_raw;
  logic             i_ack;
  logic [WIDTH-1:0] o_io_sw;
  logic [WIDTH-1:0] o_sw_rise;
  logic [WIDTH-1:0] o_sw_fall;
  logic             o_sw_changed;
  logic             o_tick;

  // Stimulus / software side.
  modport master (
    output i_sw_raw, i_ack,
    input  o_io_sw, o_sw_rise, o_sw_fall, o_sw_changed, o_tick
  );

  // Debouncer side.
  modport slave (
    input  i_sw_raw, i_ack,
    output o_io_sw, o_sw_rise, o_sw_fall, o_sw_changed, o_tick
  );
endinterface

// File: rtl/io_sw_debounce.sv
// Slide-switch conditioner: 2-flop sync, divided-tick sampling, N-equal-sample acceptance.
// Latency: 2 sync edges + STABLE_SAMPLES ticks (TICK_DIV=1: STABLE_SAMPLES+2 edges).
// Backpressure: none; outputs are registered levels/pulses, i_ack clears the sticky flag.
//
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous active-high reset
//   bus      io_sw_debounce_if.slave: raw switches and ack in; debounced word,
//            edge pulses, sticky changed flag and sample strobe out
module io_sw_debounce #(
  parameter int WIDTH          = 32,
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  io_sw_debounce_if.slave   bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]                      tick_cnt;
  logic                                  tick;
  logic [WIDTH-1:0]                      sync1;
  logic [WIDTH-1:0]                      sync2;
  logic [WIDTH-1:0][STABLE_SAMPLES-1:0]  hist;
  logic [WIDTH-1:0][STABLE_SAMPLES-1:0]  hist_nxt;
  logic [WIDTH-1:0]                      sw_nxt;
  logic                                  sw_diff;

  // With TICK_DIV=1 the counter is pinned at 0 and tick is permanently high.
  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Shifted history including the sample taken on this edge; acceptance looks
  // at this value so a level is taken on the same tick that completes the run.
  always_comb begin
    hist_nxt = hist;
    sw_nxt   = bus.o_io_sw;
    for (int b = 0; b < WIDTH; b++) begin
      hist_nxt[b] = {hist[b][STABLE_SAMPLES-2:0], sync2[b]};
      if (&hist_nxt[b]) begin
        sw_nxt[b] = 1'b1;
      end else if (~|hist_nxt[b]) begin
        sw_nxt[b] = 1'b0;
      end
    end
  end

  assign sw_diff = tick && (sw_nxt != bus.o_io_sw);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt         <= '0;
      sync1            <= '0;
      sync2            <= '0;
      hist             <= '0;
      bus.o_io_sw      <= '0;
      bus.o_sw_rise    <= '0;
      bus.o_sw_fall    <= '0;
      bus.o_sw_changed <= 1'b0;
      bus.o_tick       <= 1'b0;
    end else begin
      sync1      <= bus.i_sw_raw;
      sync2      <= sync1;
      bus.o_tick <= tick;

      if (tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (tick) begin
        hist          <= hist_nxt;
        bus.o_io_sw   <= sw_nxt;
        bus.o_sw_rise <= sw_nxt & ~bus.o_io_sw;
        bus.o_sw_fall <= ~sw_nxt & bus.o_io_sw;
      end else begin
        bus.o_sw_rise <= '0;
        bus.o_sw_fall <= '0;
      end

      // A change on the same edge as an ack keeps the flag set.
      if (sw_diff) begin
        bus.o_sw_changed <= 1'b1;
      end else if (bus.i_ack) begin
        bus.o_sw_changed <= 1'b0;
      end
    end
  end

endmodule
